stepmul_mul_pipe: RTL

Parametrised, pipelined multiplier for the STEPMUL datapath, the successor to the single-cycle fixed-width multiplier cores. Operand widths, result width and pipeline depth are set by parameters. Signedness of each operand and the result half are chosen per transaction. Valid/ready handshakes on both sides, with bubble-collapsing backpressure, let it sit between the NTT/step schedulers and the reduction units without external FIFOs.

---
 rtl/stepmul_pkg.sv | 45 ++++
 rtl/stepmul_pipe_stage.sv | 60 ++++++
 rtl/stepmul_mul_pipe.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/stepmul_pkg.sv
// Shared helpers for the STEPMUL multiplier pipeline: operand extension,
// result half select and the occupancy counter width.
// Latency: n/a (pure functions and constants). Backpressure: n/a.
package stepmul_pkg;

    // Widest operand the helper functions accept; the product buses are
    // twice that so any legal operand pair fits.
    localparam int STEPMUL_MAXW = 64;
    localparam int STEPMUL_MAXP = 2 * STEPMUL_MAXW;

    // Bits needed to count 0..num_stage valid stages.
    function automatic int stepmul_occ_w(input int num_stage);
        return (num_stage < 1) ? 1 : $clog2(num_stage + 1);
    endfunction

    // Extends a width-bit operand (held in the low bits of val) to the full
    // return width. Every bit at or above 'width' is filled with the sign bit
    // when is_signed is set and with zero otherwise, so callers may truncate
    // the signed result to any size of at least width+1 bits.
    function automatic logic signed [STEPMUL_MAXW:0] stepmul_ext(
        input logic [STEPMUL_MAXW-1:0] val,
        input int                      width,
        input logic                    is_signed
    );
        logic [STEPMUL_MAXW-1:0] keep;
        logic [STEPMUL_MAXW-1:0] msb_shift;
        logic                    fill;
        keep      = ~({STEPMUL_MAXW{1'b1}} << width);
        msb_shift = val >> (width - 1);
        fill      = is_signed & msb_shift[0];
        return {fill, (val & keep) | ({STEPMUL_MAXW{fill}} & ~keep)};
    endfunction

    // Picks the upper or lower dout_w bits of a prod_w-bit product. The
    // caller truncates the returned bus to dout_w bits.
    function automatic logic [STEPMUL_MAXP-1:0] stepmul_sel(
        input logic [STEPMUL_MAXP-1:0] prod,
        input int                      prod_w,
        input int                      dout_w,
        input logic                    hi
    );
        return hi ? (prod >> (prod_w - dout_w)) : prod;
    endfunction

endpackage

// File: rtl/stepmul_pipe_stage.sv
// One register slice of the multiplier pipeline: valid bit, result and tag.
// Latency: 1 cycle per slice. Backpressure: holds its contents until adv_out.
// Ports: clk/reset (async, active-high); vld_in/dat_in/tag_in from upstream,
//        adv_in = upstream advances into this slice, adv_out = this slice
//        advances downstream; vld/dat/tag = registered slice contents.
module stepmul_pipe_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vld_in,
    input  logic                  adv_in,
    input  logic                  adv_out,
    input  logic [DATA_WIDTH-1:0] dat_in,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    output logic                  vld,
    output logic [DATA_WIDTH-1:0] dat,
    output logic [TAG_WIDTH-1:0]  tag
);

    logic                  vld_q, vld_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;

    // adv_in is only ever high when this slice is empty or is itself
    // advancing, so taking the upstream valid never overwrites a live item.
    // Data only moves when a real item arrives; empty slices keep stale data.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        tag_d = tag_q;
        if (adv_in) begin
            vld_d = vld_in;
            if (vld_in) begin
                dat_d = dat_in;
                tag_d = tag_in;
            end
        end else if (adv_out) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= 1'b0;
            dat_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            tag_q <= tag_d;
        end
    end

    assign vld = vld_q;
    assign dat = dat_q;
    assign tag = tag_q;

endmodule

// File: rtl/stepmul_mul_pipe.sv
// Pipelined signed/unsigned multiplier with per-transaction hi/lo select and tag.
// Latency: NUM_STAGE cycles from accept to out_valid when not stalled.
// Backpressure: valid/ready, bubble-collapsing; in_ready is combinational on out_ready.
// Ports: clk, reset (async, active-high), ce (global freeze);
//        in_valid/in_ready, din0/din1, din0_signed/din1_signed, hi_sel, in_tag;
//        out_valid/out_ready, dout, out_tag; occupancy = number of valid stages.
module stepmul_mul_pipe
    import stepmul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 16,
    parameter int dout_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 ce,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [din0_WIDTH-1:0]                din0,
    input  logic [din1_WIDTH-1:0]                din1,
    input  logic                                 din0_signed,
    input  logic                                 din1_signed,
    input  logic                                 hi_sel,
    input  logic [TAG_WIDTH-1:0]                 in_tag,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [dout_WIDTH-1:0]                dout,
    output logic [TAG_WIDTH-1:0]                 out_tag,
    output logic [stepmul_occ_w(NUM_STAGE)-1:0]  occupancy
);

    localparam int PW  = din0_WIDTH + din1_WIDTH;
    localparam int PFW = PW + 2;
    localparam int OW  = stepmul_occ_w(NUM_STAGE);

    generate
        if (dout_WIDTH > din0_WIDTH + din1_WIDTH || dout_WIDTH < 1 ||
            NUM_STAGE < 1 || din0_WIDTH < 1 || din1_WIDTH < 1 ||
            din0_WIDTH > STEPMUL_MAXW || din1_WIDTH > STEPMUL_MAXW ||
            TAG_WIDTH < 1 || ID < 0) begin : g_param_err
            $error("stepmul_mul_pipe: illegal parameter combination");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Product and select, combinational at the input
    // ------------------------------------------------------------------
    logic signed [PFW-1:0]  op0, op1;
    logic [PW-1:0]          prod;
    logic [dout_WIDTH-1:0]  sel_res;

    // Both operands get one extra bit (sign or zero) and are then multiplied
    // as signed numbers, which covers all four signedness combinations. The
    // low PW bits of the signed product are the exact result in every case.
    always_comb begin
        op0     = PFW'(stepmul_ext(STEPMUL_MAXW'(din0), din0_WIDTH, din0_signed));
        op1     = PFW'(stepmul_ext(STEPMUL_MAXW'(din1), din1_WIDTH, din1_signed));
        prod    = PW'(op0 * op1);
        sel_res = dout_WIDTH'(stepmul_sel(STEPMUL_MAXP'(prod), PW, dout_WIDTH, hi_sel));
    end

    // ------------------------------------------------------------------
    // Stage chain; index 0 is the input port, NUM_STAGE is the output
    // ------------------------------------------------------------------
    logic [NUM_STAGE:0]                 vld_chain;
    logic [NUM_STAGE:0][dout_WIDTH-1:0] dat_chain;
    logic [NUM_STAGE:0][TAG_WIDTH-1:0]  tag_chain;
    logic [NUM_STAGE:0]                 adv_vec;

    assign vld_chain[0] = in_valid;
    assign dat_chain[0] = sel_res;
    assign tag_chain[0] = in_tag;

    // adv_vec[k]: stage k hands its contents on this cycle. A stage may
    // advance whenever anything downstream has room, whether or not it holds
    // an item itself, which is what lets bubbles collapse under a stall.
    // adv_vec[0] is the input acceptance, i.e. in_ready.
    always_comb begin
        adv_vec            = '0;
        adv_vec[NUM_STAGE] = ce & vld_chain[NUM_STAGE] & out_ready;
        for (int k = NUM_STAGE - 1; k >= 1; k--) begin
            adv_vec[k] = ce & (~vld_chain[k+1] | adv_vec[k+1]);
        end
        adv_vec[0] = ce & ~reset & (~vld_chain[1] | adv_vec[1]);
    end

    generate
        for (genvar k = 1; k <= NUM_STAGE; k++) begin : g_stage
            stepmul_pipe_stage #(
                .DATA_WIDTH (dout_WIDTH),
                .TAG_WIDTH  (TAG_WIDTH)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .vld_in  (vld_chain[k-1]),
                .adv_in  (adv_vec[k-1]),
                .adv_out (adv_vec[k]),
                .dat_in  (dat_chain[k-1]),
                .tag_in  (tag_chain[k-1]),
                .vld     (vld_chain[k]),
                .dat     (dat_chain[k]),
                .tag     (tag_chain[k])
            );
        end
    endgenerate

    assign in_ready  = adv_vec[0];
    assign out_valid = vld_chain[NUM_STAGE];
    assign dout      = dat_chain[NUM_STAGE];
    assign out_tag   = tag_chain[NUM_STAGE];

    // ------------------------------------------------------------------
    // Occupancy: tracks popcount of the stage valid bits
    // ------------------------------------------------------------------
    logic [OW-1:0] occ_q, occ_d;
    logic          in_fire;
    logic          out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = adv_vec[NUM_STAGE];

    always_comb begin
        occ_d = occ_q;
        if (in_fire & ~out_fire) begin
            occ_d = occ_q + OW'(1);
        end else if (~in_fire & out_fire) begin
            occ_d = occ_q - OW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule
